// File: rtl/tx_arb_ctrl.sv
// tx_arb_ctrl: four-way round-robin arbiter feeding an 8N1 serial transmitter.
// A grant latches the winner's byte, pulses its ack for one cycle and sends
// one frame on tx: start bit, eight data bits LSB first, then the stop bit.
// If a request is pending at the end of a stop bit, the next frame starts
// directly with no idle gap between frames.
module tx_arb_ctrl #(
  parameter int CLKS_PER_BIT = 16,
  parameter int NUM_REQ      = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     ack,
  output logic [1:0]             grant_id,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   tx
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [15:0] CNT_MAX = 16'(CLKS_PER_BIT - 1);

  state_t               state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [7:0]           shift_q, shift_d;
  logic [1:0]           grant_q, grant_d;
  logic [1:0]           last_q, last_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 busy_q, busy_d;
  logic                 frame_done_q, frame_done_d;
  logic                 tx_q, tx_d;
  logic                 grant_now;
  logic [2:0]           pick;

  // Returns {found, index}. The search starts one past the last winner, so
  // the last winner itself has the lowest priority. The loop runs from the
  // lowest priority up, so the highest-priority hit is the one that sticks.
  function automatic logic [2:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                         input logic [1:0]         last);
    logic [1:0] idx;
    rr_pick = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (r[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

  // Next-state logic: FSM sequencing, baud counter, arbitration and output values
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 16'd1;
    bit_d     = bit_q;
    shift_d   = shift_q;
    grant_d   = grant_q;
    last_d    = last_q;
    ack_d     = '0;
    busy_d    = busy_q;
    tx_d      = tx_q;
    grant_now = 1'b0;
    pick      = rr_pick(req, last_q);

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pick[2]) grant_now = 1'b1;
      end
      START: begin
        if (cnt_q == CNT_MAX) begin
          state_d = DATA;
          cnt_d   = '0;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
            bit_d   = bit_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d = '0;
          if (pick[2]) begin
            grant_now = 1'b1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // A grant takes priority over the state's own transition: the next frame's
    // start bit begins on the cycle right after the grant edge.
    if (grant_now) begin
      state_d          = START;
      cnt_d            = '0;
      shift_d          = req_data[{pick[1:0], 3'b000} +: 8];
      grant_d          = pick[1:0];
      last_d           = pick[1:0];
      ack_d[pick[1:0]] = 1'b1;
      busy_d           = 1'b1;
      tx_d             = 1'b0;
    end

    frame_done_d = (state_d == STOP) && (cnt_d == CNT_MAX);
  end

  // Control state and registered outputs; reset forces an idle line at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      grant_q      <= '0;
      last_q       <= 2'd3;
      ack_q        <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      tx_q         <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      grant_q      <= grant_d;
      last_q       <= last_d;
      ack_q        <= ack_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      tx_q         <= tx_d;
    end
  end

  // Data shift register; it is always loaded at a grant before it is used
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign ack        = ack_q;
  assign grant_id   = grant_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign tx         = tx_q;

endmodule
